// File: rtl/bus_master_arb.sv
// Four-master round-robin bus arbiter with the owner's address/strobe/direction/data
// multiplexed onto the shared slave-side bus.
module bus_master_arb #(
  parameter int HOLD_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_,
  input  logic [29:0] m0_addr,
  input  logic        m0_as_,
  input  logic        m0_rw,
  input  logic [31:0] m0_wr_data,
  input  logic        m1_req_,
  input  logic [29:0] m1_addr,
  input  logic        m1_as_,
  input  logic        m1_rw,
  input  logic [31:0] m1_wr_data,
  input  logic        m2_req_,
  input  logic [29:0] m2_addr,
  input  logic        m2_as_,
  input  logic        m2_rw,
  input  logic [31:0] m2_wr_data,
  input  logic        m3_req_,
  input  logic [29:0] m3_addr,
  input  logic        m3_as_,
  input  logic        m3_rw,
  input  logic [31:0] m3_wr_data,
  output logic        m0_grnt_,
  output logic        m1_grnt_,
  output logic        m2_grnt_,
  output logic        m3_grnt_,
  output logic [29:0] s_addr,
  output logic        s_as_,
  output logic        s_rw,
  output logic [31:0] s_wr_data,
  output logic [1:0]  bus_owner
);

  logic [3:0] req;
  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic [1:0] rr_next;
  logic       rr_found;
  logic [7:0] hold_cnt;
  logic [3:0] grnt_q;
  logic       hold_done;
  logic       force_rot;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Scan from the farthest candidate so the nearest requester after owner wins.
  always_comb begin
    rr_found = 1'b0;
    rr_next  = owner;
    for (int k = 3; k >= 1; k--) begin
      if (req[owner + 2'(k)]) begin
        rr_found = 1'b1;
        rr_next  = owner + 2'(k);
      end
    end
  end

  always_comb begin
    s_addr    = m0_addr;
    s_as_     = m0_as_;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    case (owner)
      2'd1: begin
        s_addr    = m1_addr;
        s_as_     = m1_as_;
        s_rw      = m1_rw;
        s_wr_data = m1_wr_data;
      end
      2'd2: begin
        s_addr    = m2_addr;
        s_as_     = m2_as_;
        s_rw      = m2_rw;
        s_wr_data = m2_wr_data;
      end
      2'd3: begin
        s_addr    = m3_addr;
        s_as_     = m3_as_;
        s_rw      = m3_rw;
        s_wr_data = m3_wr_data;
      end
      default: ;
    endcase
  end

  // Fairness limit reached: owner has held through HOLD_MAX cycles of contention.
  generate
    if (HOLD_MAX == 0) begin : g_no_limit
      assign hold_done = 1'b0;
    end else if (HOLD_MAX == 1) begin : g_limit_one
      assign hold_done = 1'b1;
    end else begin : g_limit
      assign hold_done = (hold_cnt >= 8'(HOLD_MAX - 1));
    end
  endgenerate

  // A strobe in flight (s_as_ low) is never preempted.
  assign force_rot = req[owner] & rr_found & hold_done & s_as_;

  always_comb begin
    owner_nxt = owner;
    if ((!req[owner] && rr_found) || force_rot) begin
      owner_nxt = rr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= 2'd0;
      hold_cnt <= 8'd0;
      grnt_q   <= 4'b1110;
    end else begin
      owner  <= owner_nxt;
      grnt_q <= ~(4'b0001 << owner_nxt);
      if ((owner_nxt != owner) || !rr_found) begin
        hold_cnt <= 8'd0;
      end else if (hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  // Grants come straight from a one-hot register so they cannot glitch.
  assign m0_grnt_  = grnt_q[0];
  assign m1_grnt_  = grnt_q[1];
  assign m2_grnt_  = grnt_q[2];
  assign m3_grnt_  = grnt_q[3];
  assign bus_owner = owner;

endmodule

// File: tb/tb_bus_master_arb.sv
// Randomized and directed bench for bus_master_arb against a cycle-level
// round-robin reference model.
module tb_bus_master_arb;

  localparam int HM = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req_n;
  logic [3:0]  as_n;
  logic [3:0]  rw;
  logic [29:0] addr [4];
  logic [31:0] wd [4];
  logic [3:0]  grnt_n;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;
  logic [1:0]  bus_owner;

  int n_checks = 0;
  int n_fail = 0;
  int m_owner = 0;
  int m_hold = 0;

  bus_master_arb #(.HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m0_addr(addr[0]), .m0_as_(as_n[0]), .m0_rw(rw[0]), .m0_wr_data(wd[0]),
    .m1_req_(req_n[1]), .m1_addr(addr[1]), .m1_as_(as_n[1]), .m1_rw(rw[1]), .m1_wr_data(wd[1]),
    .m2_req_(req_n[2]), .m2_addr(addr[2]), .m2_as_(as_n[2]), .m2_rw(rw[2]), .m2_wr_data(wd[2]),
    .m3_req_(req_n[3]), .m3_addr(addr[3]), .m3_as_(as_n[3]), .m3_rw(rw[3]), .m3_wr_data(wd[3]),
    .m0_grnt_(grnt_n[0]), .m1_grnt_(grnt_n[1]), .m2_grnt_(grnt_n[2]), .m3_grnt_(grnt_n[3]),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .bus_owner(bus_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s_grnt%0d", tag, n), 64'(grnt_n[n]), 64'(m_owner != n));
    end
    chk({tag, "_owner"}, 64'(bus_owner), 64'(m_owner));
    chk({tag, "_s_addr"}, 64'(s_addr), 64'(addr[m_owner]));
    chk({tag, "_s_as"}, 64'(s_as_), 64'(as_n[m_owner]));
    chk({tag, "_s_rw"}, 64'(s_rw), 64'(rw[m_owner]));
    chk({tag, "_s_wd"}, 64'(s_wr_data), 64'(wd[m_owner]));
  endtask

  // Reference: pick the nearest requester after the owner; keep, release or rotate.
  task automatic model_step();
    int nxt;
    int nw;
    nxt = -1;
    for (int k = 1; k <= 3; k++) begin
      if (nxt < 0 && !req_n[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
    end
    nw = m_owner;
    if (req_n[m_owner]) begin
      if (nxt >= 0) nw = nxt;
    end else if (HM != 0 && nxt >= 0 && m_hold >= HM - 1 && as_n[m_owner]) begin
      nw = nxt;
    end
    if (nw != m_owner || nxt < 0) m_hold = 0;
    else if (m_hold < 255) m_hold++;
    m_owner = nw;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #1 reset = 1'b1;
    #1;
    m_owner = 0;
    m_hold = 0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_master(input int n);
    addr[n] = 30'($urandom);
    wd[n]   = $urandom;
    rw[n]   = 1'($urandom);
    as_n[n] = 1'($urandom);
  endtask

  initial begin
    int edges;
    reset = 1'b1;
    req_n = 4'hF;
    as_n  = 4'hF;
    for (int n = 0; n < 4; n++) begin
      addr[n] = 30'($urandom);
      wd[n]   = $urandom;
      rw[n]   = 1'($urandom);
    end
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // simple handover 0 -> 1
    req_n = 4'b1101;
    addr[1] = 30'h0000_1234;
    step("handover");
    chk("handover_owner", 64'(bus_owner), 64'd1);
    chk("handover_addr", 64'(s_addr), 64'h1234);

    // round robin: everyone requests, owner drops after one cycle
    for (int i = 0; i < 4; i++) begin
      req_n = 4'b0000;
      req_n[bus_owner] = 1'b1;
      step("rr");
      chk("rr_seq", 64'(bus_owner), 64'((i + 2) % 4));
    end
    req_n = 4'b1011;
    step("to2");
    req_n = 4'b0111;
    step("to3");
    req_n = 4'b1001;
    step("skip0");
    chk("skip0_owner", 64'(bus_owner), 64'd1);

    // parking on owner 1
    req_n = 4'b1111;
    step("park");
    chk("park_owner", 64'(bus_owner), 64'd1);
    req_n = 4'b1101;
    step("park_rereq");
    chk("park_rereq_grnt1", 64'(grnt_n[1]), 64'd0);

    // non-owner isolation
    reset_pulse("rst_iso");
    req_n = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      rand_master(3);
      #1 check_all("iso_mux");
      step("iso");
    end

    // forced rotation after exactly HM contended cycles
    reset_pulse("rst_force");
    as_n = 4'hF;
    req_n = 4'b1010;
    edges = 0;
    while (grnt_n[2] !== 1'b0 && edges < 20) begin
      step("force");
      edges++;
    end
    chk("force_cycles", 64'(edges), 64'(HM));

    // strobe in flight blocks rotation until it ends
    req_n = 4'b0011;
    as_n[2] = 1'b0;
    for (int i = 0; i < 10; i++) step("force_hold");
    chk("force_hold_owner", 64'(bus_owner), 64'd2);
    as_n[2] = 1'b1;
    step("force_release");
    chk("force_release_owner", 64'(bus_owner), 64'd3);

    // reset mid-transfer from owner 2
    req_n = 4'b1011;
    step("to2b");
    as_n[2] = 1'b0;
    #1 check_all("xfer2");
    reset_pulse("rst_mid");

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < 4; n++) begin
        req_n[n] = ($urandom_range(0, 9) < 3);
        rand_master(n);
      end
      #1 check_all("rnd_mux");
      if ($urandom_range(0, 60) == 0) reset_pulse("rnd_rst");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
